ram_latency_model: RTL and testbench

Word-addressed RAM responder at the far end of the memory controller's RAM port. It accepts ramREN/ramWEN requests, stalls for a fixed latency, then completes the access and reports progress on ramstate. It is the simulation and FPGA-prototype stand-in for main memory beneath the coherence/bus controller. Types (word_t, ramstate_t: FREE, BUSY, ACCESS, ERROR) come from cpu_types_pkg.

---
 rtl/ram_latency_model.sv | 114 +++++++++++
 tb/tb_ram_latency_model.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_latency_model.sv
// Word-addressed RAM responder: accepts a level read/write request, stalls LAT cycles,
// then completes the access and reports progress on ramstate (FREE/BUSY/ACCESS/ERROR).
module ram_latency_model #(
    parameter int LAT       = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    // State encodings equal the ramstate encodings, so ramstate is the FSM state itself.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    state_t                 state;
    logic [3:0]             cnt;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic                   lat_wr;
    logic [31:0]            mem [DEPTH];

    logic                   req_any;
    logic                   req_valid;
    logic                   same_req;
    logic                   fire;
    logic [ADDR_BITS-1:0]   idx;

    // Handshake: the controller holds exactly one enable high with a stable address until it
    // sees ACCESS; dropping the enables early aborts, and changing address/op restarts the wait.
    always_comb begin
        req_any   = ramREN | ramWEN;
        req_valid = (ramREN ^ ramWEN) && (ramaddr[1:0] == 2'b00) &&
                    (ramaddr[31:ADDR_BITS+2] == '0);
        idx       = ramaddr[ADDR_BITS+1:2];
        same_req  = (idx == lat_addr) && (ramWEN == lat_wr);
        fire      = 1'b0;
        case (state)
            S_IDLE, S_DONE: fire = req_valid && (LAT == 0);
            S_WAIT:         fire = req_valid && same_req && (cnt == 4'd0);
            default:        fire = 1'b0;
        endcase
    end

    // A firing access always matches the live request, so idx/ramWEN stand in for the latched copy.
    always_ff @(posedge CLK) begin
        if (!RST && fire && ramWEN) begin
            mem[idx] <= ramstore;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            ramload  <= 32'h0;
        end else begin
            if (fire && !ramWEN) begin
                ramload <= mem[idx];
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (!req_any) begin
                        state <= S_IDLE;
                    end else if (!req_valid) begin
                        state <= S_ERR;
                    end else begin
                        lat_addr <= idx;
                        lat_wr   <= ramWEN;
                        cnt      <= CNT_INIT;
                        state    <= (LAT == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req_any) begin
                        state <= S_IDLE;
                    end else if (!req_valid) begin
                        state <= S_ERR;
                    end else if (!same_req) begin
                        lat_addr <= idx;
                        lat_wr   <= ramWEN;
                        cnt      <= CNT_INIT;
                    end else if (cnt == 4'd0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ERR: begin
                    if (!req_any) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ramstate = state;

endmodule

// File: tb/tb_ram_latency_model.sv
// Bench for ram_latency_model: table-driven per-cycle vectors against a LAT=4 instance,
// plus hand-written back-to-back and LAT=0 sequences.
module tb_ram_latency_model;

    localparam int         LAT    = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef struct {
        logic        rst;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [1:0]  exp_state;
        logic        chk_load;
        logic [31:0] exp_load;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = '0, store = '0;
    logic [31:0] load_o;
    logic [1:0]  state_o;

    logic        rst0 = 1'b1, ren0 = 1'b0, wen0 = 1'b0;
    logic [31:0] addr0 = '0, store0 = '0;
    logic [31:0] load0_o;
    logic [1:0]  state0_o;

    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;

    ram_latency_model #(.LAT(LAT), .ADDR_BITS(10)) dut (
        .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen),
        .ramaddr(addr), .ramstore(store), .ramload(load_o), .ramstate(state_o)
    );

    ram_latency_model #(.LAT(0), .ADDR_BITS(10)) dut0 (
        .CLK(clk), .RST(rst0), .ramREN(ren0), .ramWEN(wen0),
        .ramaddr(addr0), .ramstore(store0), .ramload(load0_o), .ramstate(state0_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic void add(input logic r, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] st, input logic ck,
                                input logic [31:0] ld, input string nm);
        vec_t v;
        v.rst = r; v.ren = rd; v.wen = wr; v.addr = a; v.store = d;
        v.exp_state = st; v.chk_load = ck; v.exp_load = ld; v.name = nm;
        vecs.push_back(v);
    endfunction

    // Full access with the request held: LAT BUSY cycles, one ACCESS, optionally an idle cycle.
    function automatic void add_access(input string nm, input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic idle);
        for (int i = 0; i < LAT; i++) add(1'b0, !wr, wr, a, d, BUSY, 1'b0, '0, nm);
        add(1'b0, !wr, wr, a, d, ACCESS, !wr, d, nm);
        if (idle) add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, nm);
    endfunction

    // driver tasks
    task automatic apply_vec(input vec_t v, input int i);
        @(negedge clk);
        rst = v.rst; ren = v.ren; wen = v.wen; addr = v.addr; store = v.store;
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d]_state", v.name, i), {30'b0, state_o}, {30'b0, v.exp_state});
        if (v.chk_load) check($sformatf("%s[%0d]_load", v.name, i), load_o, v.exp_load);
    endtask

    task automatic step0(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] st, input logic ck,
                         input logic [31:0] ld, input string nm);
        @(negedge clk);
        rst0 = r; ren0 = rd; wen0 = wr; addr0 = a; store0 = d;
        @(posedge clk);
        #1;
        check({nm, "_state"}, {30'b0, state0_o}, {30'b0, st});
        if (ck) check({nm, "_load"}, load0_o, ld);
    endtask

    initial begin
        int cyc;
        int last;
        int n;

        add(1'b1, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h0, "reset");
        add(1'b1, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h0, "reset");
        add_access("wr100", 1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
        add_access("rd100", 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'hDEADBEEF, "load_hold");
        // reset with a read pending
        add(1'b0, 1'b1, 1'b0, 32'h100, '0, BUSY, 1'b0, '0, "rst_mid");
        add(1'b0, 1'b1, 1'b0, 32'h100, '0, BUSY, 1'b0, '0, "rst_mid");
        add(1'b1, 1'b1, 1'b0, 32'h100, '0, FREE, 1'b1, 32'h0, "rst_mid");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h0, "rst_mid_after");
        // reset on the edge that would commit a write
        for (int i = 0; i < LAT; i++) add(1'b0, 1'b0, 1'b1, 32'h100, 32'h11111111, BUSY, 1'b0, '0, "rst_done");
        add(1'b1, 1'b0, 1'b1, 32'h100, 32'h11111111, FREE, 1'b1, 32'h0, "rst_done");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "rst_done");
        add_access("rd100_post_rst", 1'b0, 32'h100, 32'hDEADBEEF, 1'b1);
        add_access("wr200", 1'b1, 32'h200, 32'h00000200, 1'b1);
        add_access("wr204", 1'b1, 32'h204, 32'hA5A50204, 1'b1);
        // address change after two BUSY cycles
        add(1'b0, 1'b1, 1'b0, 32'h200, '0, BUSY, 1'b0, '0, "restart");
        add(1'b0, 1'b1, 1'b0, 32'h200, '0, BUSY, 1'b0, '0, "restart");
        add_access("restart", 1'b0, 32'h204, 32'hA5A50204, 1'b1);
        // address change on the cnt==0 edge
        for (int i = 0; i < LAT; i++) add(1'b0, 1'b1, 1'b0, 32'h204, '0, BUSY, 1'b0, '0, "restart_cnt0");
        add_access("restart_cnt0", 1'b0, 32'h200, 32'h00000200, 1'b1);
        // write aborted by dropping WEN
        add_access("wr300", 1'b1, 32'h300, 32'h00000300, 1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h300, 32'hBAD0BAD0, BUSY, 1'b0, '0, "abort_wr");
        add(1'b0, 1'b0, 1'b1, 32'h300, 32'hBAD0BAD0, BUSY, 1'b0, '0, "abort_wr");
        add(1'b0, 1'b0, 1'b0, 32'h300, 32'hBAD0BAD0, FREE, 1'b0, '0, "abort_wr");
        add_access("rd300", 1'b0, 32'h300, 32'h00000300, 1'b1);
        // error cases
        add(1'b0, 1'b1, 1'b1, 32'h100, '0, ERROR, 1'b0, '0, "err_both");
        add(1'b0, 1'b1, 1'b1, 32'h100, '0, ERROR, 1'b0, '0, "err_both");
        add(1'b0, 1'b1, 1'b0, 32'h100, '0, ERROR, 1'b0, '0, "err_hold_one");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "err_both");
        add(1'b0, 1'b1, 1'b0, 32'h102, '0, ERROR, 1'b0, '0, "err_misalign");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "err_misalign");
        add(1'b0, 1'b1, 1'b0, 32'h1000, '0, ERROR, 1'b0, '0, "err_range");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "err_range");
        add(1'b0, 1'b0, 1'b1, 32'h80000000, '0, ERROR, 1'b0, '0, "err_range_hi");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "err_range_hi");
        add(1'b0, 1'b1, 1'b0, 32'h100, '0, BUSY, 1'b0, '0, "err_mid_wait");
        add(1'b0, 1'b1, 1'b0, 32'h102, '0, ERROR, 1'b0, '0, "err_mid_wait");
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "err_mid_wait");
        // op change read->write restarts, then the write lands
        add(1'b0, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, BUSY, 1'b0, '0, "op_change");
        add(1'b0, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, BUSY, 1'b0, '0, "op_change");
        add_access("op_change", 1'b1, 32'h100, 32'hCAFEF00D, 1'b1);
        add_access("rd_op_change", 1'b0, 32'h100, 32'hCAFEF00D, 1'b1);
        // write then read with no FREE gap
        add_access("wr10_nogap", 1'b1, 32'h10, 32'h5A5A0010, 1'b0);
        add_access("rd10_nogap", 1'b0, 32'h10, 32'h5A5A0010, 1'b1);
        add_access("wr0", 1'b1, 32'h0, 32'h10000000, 1'b1);
        add_access("wr4", 1'b1, 32'h4, 32'h10000004, 1'b1);
        add_access("wr8", 1'b1, 32'h8, 32'h10000008, 1'b1);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // back-to-back reads with ramREN held, stepping the address on each ACCESS
        exp_q.push_back(32'h10000000);
        exp_q.push_back(32'h10000004);
        exp_q.push_back(32'h10000008);
        cyc = 0; last = 0; n = 0;
        @(negedge clk);
        rst = 1'b0; ren = 1'b1; wen = 1'b0; addr = 32'h0;
        while (n < 3 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            check("b2b_not_free", {31'b0, state_o != FREE}, 32'd1);
            if (state_o == ACCESS) begin
                check("b2b_period", 32'(cyc - last), 32'(LAT + 1));
                check("b2b_data", load_o, exp_q.pop_front());
                n++;
                last = cyc;
                if (n < 3) begin
                    @(negedge clk);
                    addr = addr + 32'd4;
                end
            end
        end
        check("b2b_count", 32'(n), 32'd3);
        @(negedge clk);
        ren = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_release", {30'b0, state_o}, {30'b0, FREE});

        // LAT=0 instance
        step0(1'b1, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h0, "l0_reset");
        step0(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000AAAA, ACCESS, 1'b0, '0, "l0_wr0");
        step0(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "l0_idle");
        step0(1'b0, 1'b0, 1'b1, 32'h3FC, 32'h3FC03FC0, ACCESS, 1'b1, 32'h0, "l0_wr3fc");
        step0(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "l0_idle");
        step0(1'b0, 1'b1, 1'b0, 32'h3FC, '0, ACCESS, 1'b1, 32'h3FC03FC0, "l0_rd3fc");
        step0(1'b0, 1'b1, 1'b0, 32'h0, '0, ACCESS, 1'b1, 32'h0000AAAA, "l0_rd0");
        step0(1'b0, 1'b1, 1'b0, 32'h3FC, '0, ACCESS, 1'b1, 32'h3FC03FC0, "l0_rd3fc_again");
        step0(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h3FC03FC0, "l0_hold");
        step0(1'b0, 1'b1, 1'b0, 32'h101, '0, ERROR, 1'b0, '0, "l0_err");
        step0(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0, "l0_err_release");

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
